// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 24-bit EX operand mux.
// Define HAZARD_PERF_EN to add saturating stall/flush event counters.
module hazard_forward_ctrl #(
   parameter int REG_AW       = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              idValid,
   input  logic [REG_AW-1:0] idRs1,
   input  logic [REG_AW-1:0] idRs2,
   input  logic [REG_AW-1:0] idRd,
   input  logic              idRegWrite,
   input  logic              idMemRead,
   input  logic              branchTaken,
`ifdef HAZARD_PERF_EN
   output logic [15:0]       stallCount,
   output logic [15:0]       flushCount,
`endif
   output logic              stall,
   output logic              flush,
   output logic [1:0]        fwdA,
   output logic [1:0]        fwdB
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regWrite;
      logic              isLoad;
   } stage_t;

   typedef enum logic {RUN, FLUSH} state_t;

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   stage_t     ex, mem, wb;
   logic       loaduse;
   logic       advance;
   logic [1:0] fwda_nxt, fwdb_nxt;

   function automatic logic match(stage_t s, logic [REG_AW-1:0] r);
      return s.valid & s.regWrite & (s.rd == r) & (r != '0);
   endfunction

   function automatic logic [1:0] fsel(logic [REG_AW-1:0] r);
      if (match(ex, r))
         return 2'b01;
      else if (match(mem, r))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      flush     = 1'b0;
      unique case (state)
         RUN: begin
            if (branchTaken) begin
               flush     = 1'b1;
               state_nxt = FLUSH;
               cnt_nxt   = CNT_LOAD;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            if (branchTaken)
               cnt_nxt = CNT_LOAD;
            else if (cnt == 3'd0)
               state_nxt = RUN;
            else
               cnt_nxt = cnt - 3'd1;
         end
         default: begin
            state_nxt = RUN;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   // Flush takes priority: the squashed ID instruction need not wait.
   always_comb begin
      loaduse = (state == RUN) & idValid & ex.isLoad
              & (match(ex, idRs1) | match(ex, idRs2));
      stall   = loaduse & ~flush;
      advance = ~stall & ~flush;
      fwda_nxt = 2'b00;
      fwdb_nxt = 2'b00;
      if (advance && idValid) begin
         fwda_nxt = fsel(idRs1);
         fwdb_nxt = fsel(idRs2);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex   <= '0;
         mem  <= '0;
         wb   <= '0;
         fwdA <= 2'b00;
         fwdB <= 2'b00;
      end else begin
         mem  <= ex;
         wb   <= mem;
         fwdA <= fwda_nxt;
         fwdB <= fwdb_nxt;
         if (advance && idValid) begin
            ex.valid    <= 1'b1;
            ex.rd       <= idRd;
            ex.regWrite <= idRegWrite;
            ex.isLoad   <= idMemRead;
         end else begin
            ex <= '0;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCount <= 16'd0;
         flushCount <= 16'd0;
      end else begin
         if (stall && stallCount != 16'hFFFF)
            stallCount <= stallCount + 16'd1;
         if (flush && flushCount != 16'hFFFF)
            flushCount <= flushCount + 16'd1;
      end
   end
`endif

endmodule
